// File: rtl/bcd_gray_arbiter.sv
// Two-requester round-robin front end for one shared 4-bit BCD-to-Gray converter.
// A single conversion is in flight at a time: IDLE accepts, CONV computes, RESP holds the result.
module bcd_gray_arbiter #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_gray,
  output logic             out_id,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  // Handshake: a transfer happens on any rising edge where valid and ready are both 1;
  // ready never depends on anything but state and the requesters' valids.
  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [W-1:0]       data_q, data_d;
  logic               id_q, id_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_gray_q, out_gray_d;
  logic               out_id_q, out_id_d;
  logic               out_err_q, out_err_d;
  logic [CNT_W-1:0]   done_count_q, done_count_d;

  logic               grant0, grant1;
  logic [W-1:0]       gray;

  always_comb begin
    gray   = data_q ^ (data_q >> 1);
    // On contention the requester that was not served last wins.
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);

    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    id_d         = id_q;
    out_valid_d  = out_valid_q;
    out_gray_d   = out_gray_q;
    out_id_d     = out_id_q;
    out_err_d    = out_err_q;
    done_count_d = done_count_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant0) begin
          req0_ready   = 1'b1;
          data_d       = req0_data;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = CONV;
        end else if (grant1) begin
          req1_ready   = 1'b1;
          data_d       = req1_data;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = CONV;
        end
      end
      CONV: begin
        out_gray_d  = gray;
        out_id_d    = id_q;
        out_err_d   = (data_q > W'(9));
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (done_count_q != {CNT_W{1'b1}}) done_count_d = done_count_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      id_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_gray_q   <= '0;
      out_id_q     <= 1'b0;
      out_err_q    <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      id_q         <= id_d;
      out_valid_q  <= out_valid_d;
      out_gray_q   <= out_gray_d;
      out_id_q     <= out_id_d;
      out_err_q    <= out_err_d;
      done_count_q <= done_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_gray   = out_gray_q;
  assign out_id     = out_id_q;
  assign out_err    = out_err_q;
  assign done_count = done_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_gray_arbiter.sv
// Bench for bcd_gray_arbiter: directed scenarios plus random traffic against a transaction-level model.
// A second instance with a 2-bit counter shares all inputs to exercise counter saturation.
module tb_bcd_gray_arbiter;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         out_ready = 1'b0;

  logic         req0_ready, req1_ready, out_valid, out_id, out_err, busy;
  logic [W-1:0] out_gray;
  logic [7:0]   done_count;

  logic         s_req0_ready, s_req1_ready, s_out_valid, s_out_id, s_out_err, s_busy;
  logic [W-1:0] s_out_gray;
  logic [1:0]   s_done_count;

  int n_cmp = 0;
  int n_fail = 0;

  bcd_gray_arbiter #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray),
    .out_id(out_id), .out_err(out_err), .busy(busy), .done_count(done_count)
  );

  bcd_gray_arbiter #(.W(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_gray(s_out_gray),
    .out_id(s_out_id), .out_err(s_out_err), .busy(s_busy), .done_count(s_done_count)
  );

  // ---------------- reference model ----------------
  // m_stage: 0 = free, 1 = converting, 2 = result on offer.
  int         m_stage = 0;
  logic       m_last = 1'b1;
  int         m_count = 0;
  int         m_w;
  logic [5:0] exp_q[$];   // {id, err, gray}

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    g[2] = b[3] ^ b[2];
    g[1] = b[2] ^ b[1];
    g[0] = b[1] ^ b[0];
    return g;
  endfunction

  function automatic int pick();
    if (m_stage != 0) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_stage = 0;
      m_last  = 1'b1;
      m_count = 0;
      exp_q.delete();
    end else begin
      case (m_stage)
        0: begin
          m_w = pick();
          if (m_w == 0) begin
            exp_q.push_back({1'b0, (req0_data > 4'd9), to_gray(req0_data)});
            m_last  = 1'b0;
            m_stage = 1;
          end else if (m_w == 1) begin
            exp_q.push_back({1'b1, (req1_data > 4'd9), to_gray(req1_data)});
            m_last  = 1'b1;
            m_stage = 1;
          end
        end
        1: m_stage = 2;
        default: begin
          if (out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_count = m_count + 1;
            m_stage = 0;
          end
        end
      endcase
    end
  end

  // ---------------- drivers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // rst must win over a pending request.
    rst = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 4'd5;
    out_ready  = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_gray, out_id, out_err, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b g=%0h id=%0b err=%0b busy=%0b expected all 0",
               out_valid, out_gray, out_id, out_err, busy);
    end
    n_cmp++;
    if (done_count !== 8'd0 || s_done_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d/%0d expected 0/0", done_count, s_done_count);
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 4'b0101;
    out_ready  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL single_accept: got rdy=%b busy=%b expected rdy=10 busy=0",
               {req0_ready, req1_ready}, busy);
    end
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_conv: got busy=%b v=%b expected busy=1 v=0", busy, out_valid);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_id, out_err, out_gray} !== {1'b1, 1'b0, 1'b0, 4'b0111}) begin
      n_fail++;
      $display("FAIL single_result: got v=%b id=%b err=%b g=%b expected v=1 id=0 err=0 g=0111",
               out_valid, out_id, out_err, out_gray);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (done_count !== 8'd1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got cnt=%0d busy=%b v=%b expected cnt=1 busy=0 v=0",
               done_count, busy, out_valid);
    end
  endtask

  task automatic test_contention();
    int g_n;
    int r_n;
    logic [5:0] exp_r;
    g_n = 0;
    r_n = 0;
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 4'b1001;
    req1_valid = 1'b1;
    req1_data  = 4'b0011;
    out_ready  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((req0_ready || req1_ready) && g_n < 4) begin
        n_cmp++;
        if ({req0_ready, req1_ready} !== ((g_n % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL contention_grant%0d: got %b expected %b", g_n,
                   {req0_ready, req1_ready}, (g_n % 2 == 0) ? 2'b10 : 2'b01);
        end
        g_n++;
      end
      if (out_valid && r_n < 4) begin
        exp_r = (r_n % 2 == 0) ? {1'b0, 1'b0, 4'b1101} : {1'b1, 1'b0, 4'b0010};
        n_cmp++;
        if ({out_id, out_err, out_gray} !== exp_r) begin
          n_fail++;
          $display("FAIL contention_result%0d: got %b expected %b", r_n,
                   {out_id, out_err, out_gray}, exp_r);
        end
        r_n++;
      end
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (g_n != 4 || r_n != 4 || done_count !== 8'd4) begin
      n_fail++;
      $display("FAIL contention_totals: got grants=%0d results=%0d cnt=%0d expected 4/4/4",
               g_n, r_n, done_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_valid = 1'b1;
    req1_data  = 4'b0110;
    out_ready  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_accept: got %b expected 01", {req0_ready, req1_ready});
    end
    next_cycle();
    req0_valid = 1'b1;
    req0_data  = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_conv_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_id, out_err, out_gray, req0_ready, req1_ready} !==
          {1'b1, 1'b1, 1'b0, 4'b0101, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b id=%b err=%b g=%b rdy=%b expected v=1 id=1 err=0 g=0101 rdy=00",
                 i, out_valid, out_id, out_err, out_gray, {req0_ready, req1_ready});
      end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || done_count !== 8'd0) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b cnt=%0d expected v=1 cnt=0", out_valid, done_count);
    end
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, req0_ready, req1_ready} !== 3'b010 || done_count !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_after: got v=%b rdy=%b cnt=%0d expected v=0 rdy=10 cnt=1",
               out_valid, {req0_ready, req1_ready}, done_count);
    end
  endtask

  task automatic test_invalid_bcd();
    do_reset();
    req1_valid = 1'b1;
    req1_data  = 4'b1100;
    out_ready  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL invalid_accept: got %b expected 01", {req0_ready, req1_ready});
    end
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_id, out_err, out_gray} !== {1'b1, 1'b1, 1'b1, 4'b1010}) begin
      n_fail++;
      $display("FAIL invalid_result: got v=%b id=%b err=%b g=%b expected v=1 id=1 err=1 g=1010",
               out_valid, out_id, out_err, out_gray);
    end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 4'b0010;
    out_ready  = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_gray} !== {1'b1, 4'b0011}) begin
      n_fail++;
      $display("FAIL midrst_first: got v=%b g=%b expected v=1 g=0011", out_valid, out_gray);
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done_count !== 8'd1) begin
      n_fail++;
      $display("FAIL midrst_conv: got busy=%b cnt=%0d expected busy=1 cnt=1", busy, done_count);
    end
    next_cycle();
    rst = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, req0_ready, req1_ready} !== 4'b0010 || done_count !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_after: got v=%b busy=%b rdy=%b cnt=%0d expected v=0 busy=0 rdy=10 cnt=0",
               out_valid, busy, {req0_ready, req1_ready}, done_count);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 4'($urandom_range(0, 15));
    out_ready  = 1'b1;
    for (int c = 0; c < 15; c++) next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_done_count !== 2'd3 || done_count !== 8'd5) begin
      n_fail++;
      $display("FAIL saturation: got sat=%0d wide=%0d expected sat=3 wide=5", s_done_count, done_count);
    end
  endtask

  task automatic test_random();
    int w;
    logic [1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_data  = 4'($urandom_range(0, 15));
      req1_data  = 4'($urandom_range(0, 15));
      out_ready  = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      if (!rst) begin
        w = pick();
        exp_rdy = {w == 0, w == 1};
        n_cmp++;
        if ({req0_ready, req1_ready} !== exp_rdy) begin
          n_fail++;
          $display("FAIL rand_ready@%0d: got %b expected %b", c, {req0_ready, req1_ready}, exp_rdy);
        end
      end
      n_cmp++;
      if ({out_valid, busy} !== {m_stage == 2, m_stage != 0}) begin
        n_fail++;
        $display("FAIL rand_status@%0d: got v=%b busy=%b expected v=%b busy=%b", c,
                 out_valid, busy, m_stage == 2, m_stage != 0);
      end
      if (m_stage == 2 && exp_q.size() > 0) begin
        n_cmp++;
        if ({out_id, out_err, out_gray} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_result@%0d: got %b expected %b", c, {out_id, out_err, out_gray}, exp_q[0]);
        end
      end
      n_cmp++;
      if (done_count !== 8'(sat(m_count, 255)) || s_done_count !== 2'(sat(m_count, 3))) begin
        n_fail++;
        $display("FAIL rand_count@%0d: got %0d/%0d expected %0d/%0d", c, done_count, s_done_count,
                 sat(m_count, 255), sat(m_count, 3));
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_invalid_bcd();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
